// File: rtl/kuznechik_encryptor.sv
// kuznechik_encryptor: iterative GOST R 34.12-2015 block encryptor (X+S in one cycle, L as 16 serial R steps)
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, keys_valid   request is accepted in IDLE only when both are high
//   block_in            plaintext, byte a15 in [127:120], a0 in [7:0]
//   key_1..key_10       round keys, must stay stable while busy
//   data_out, done      ciphertext and its one-cycle update strobe
//   busy                high from accept until the done edge
module kuznechik_encryptor (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         keys_valid,
  input  logic [127:0] block_in,
  input  logic [127:0] key_1,
  input  logic [127:0] key_2,
  input  logic [127:0] key_3,
  input  logic [127:0] key_4,
  input  logic [127:0] key_5,
  input  logic [127:0] key_6,
  input  logic [127:0] key_7,
  input  logic [127:0] key_8,
  input  logic [127:0] key_9,
  input  logic [127:0] key_10,
  output logic [127:0] data_out,
  output logic         done,
  output logic         busy
);
  localparam logic [0:255][7:0] PI = {
    128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
    128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
    128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
    128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
    128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
    128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
    128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
    128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6};
  // l coefficients, byte i holds the multiplier for a_i
  localparam logic [127:0] LC = 128'h94208510C2C001FB01C0C21085209401;
  typedef enum logic [1:0] {IDLE, XS, LR, FIN} state_t;
  state_t       r_state;
  logic [127:0] r_st;
  logic [3:0]   r_round;
  logic [3:0]   r_step;
  logic [127:0] w_rk;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [127:0] sub(input logic [127:0] a);
    logic [127:0] s;
    for (int i = 0; i < 16; i++) s[8*i +: 8] = PI[a[8*i +: 8]];
    return s;
  endfunction
  function automatic logic [127:0] rstep(input logic [127:0] a);
    logic [7:0] l;
    l = 8'h00;
    for (int i = 0; i < 16; i++) l = l ^ gmul(a[8*i +: 8], LC[8*i +: 8]);
    return {l, a[127:8]};
  endfunction
  always_comb begin
    w_rk = key_1;
    case (r_round)
      4'd2: w_rk = key_2;
      4'd3: w_rk = key_3;
      4'd4: w_rk = key_4;
      4'd5: w_rk = key_5;
      4'd6: w_rk = key_6;
      4'd7: w_rk = key_7;
      4'd8: w_rk = key_8;
      4'd9: w_rk = key_9;
      default: w_rk = key_1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_st     <= '0;
      r_round  <= '0;
      r_step   <= '0;
      data_out <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start && keys_valid) begin
          r_st    <= block_in;
          r_round <= 4'd1;
          busy    <= 1'b1;
          r_state <= XS;
        end
        XS: begin
          r_st    <= sub(r_st ^ w_rk);
          r_step  <= 4'd0;
          r_state <= LR;
        end
        LR: begin
          r_st   <= rstep(r_st);
          r_step <= r_step + 4'd1;
          if (r_step == 4'd15) begin
            if (r_round == 4'd9) r_state <= FIN;
            else begin
              r_round <= r_round + 4'd1;
              r_state <= XS;
            end
          end
        end
        FIN: begin
          data_out <= r_st ^ key_10;
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_kuznechik_encryptor.sv
// tb_kuznechik_encryptor: randomized and known-answer checks of kuznechik_encryptor against a byte-level model
module tb_kuznechik_encryptor;
  localparam logic [0:255][7:0] PI_TAB = {
    128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
    128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
    128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
    128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
    128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
    128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
    128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
    128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6};
  localparam logic [0:15][7:0] LCOEF = {8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
                                        8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148};
  localparam logic [127:0] GOST_PT = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] GOST_CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, keys_valid = 1'b0, done, busy;
  logic [127:0] block_in = '0, data_out;
  logic [127:0] keys [1:10];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  kuznechik_encryptor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .keys_valid(keys_valid), .block_in(block_in),
    .key_1(keys[1]), .key_2(keys[2]), .key_3(keys[3]), .key_4(keys[4]), .key_5(keys[5]),
    .key_6(keys[6]), .key_7(keys[7]), .key_8(keys[8]), .key_9(keys[9]), .key_10(keys[10]),
    .data_out(data_out), .done(done), .busy(busy));
  function automatic logic [7:0] gf(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    p = 8'h00;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction
  function automatic logic [127:0] ref_l(input logic [127:0] a, input int n);
    logic [7:0] b [16];
    logic [7:0] t;
    logic [127:0] o;
    for (int j = 0; j < 16; j++) b[j] = a[8*j +: 8];
    repeat (n) begin
      t = 8'h00;
      for (int j = 0; j < 16; j++) t = t ^ gf(b[j], LCOEF[j]);
      for (int j = 0; j < 15; j++) b[j] = b[j+1];
      b[15] = t;
    end
    for (int j = 0; j < 16; j++) o[8*j +: 8] = b[j];
    return o;
  endfunction
  function automatic logic [127:0] ref_enc(input logic [127:0] pt);
    logic [127:0] a;
    logic [127:0] s;
    a = pt;
    for (int r = 1; r <= 9; r++) begin
      s = a ^ keys[r];
      for (int j = 0; j < 16; j++) s[8*j +: 8] = PI_TAB[s[8*j +: 8]];
      a = ref_l(s, 16);
    end
    return a ^ keys[10];
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_gost_keys;
    keys[1] = 128'h8899aabbccddeeff0011223344556677;
    keys[2] = 128'hfedcba98765432100123456789abcdef;
    keys[3] = 128'hdb31485315694343228d6aef8cc78c44;
    keys[4] = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
    keys[5] = 128'h57646468c44a5e28d3e59246f429f1ac;
    keys[6] = 128'hbd079435165c6432b532e82834da581b;
    keys[7] = 128'h51e640757e8745de705727265a0098b1;
    keys[8] = 128'h5a7925017b9fdd3ed72a91a22286f984;
    keys[9] = 128'hbb44e25378c73123a5f32f73cdb6e517;
    keys[10] = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
  endtask
  task automatic accept(input logic [127:0] pt);
    block_in = pt;
    start = 1'b1;
    keys_valid = 1'b1;
    tick();
    start = 1'b0;
    keys_valid = 1'b0;
    block_in = {$urandom, $urandom, $urandom, $urandom};
  endtask
  task automatic wait_done(output int lat, output int gaps);
    lat = 0;
    gaps = 0;
    do begin
      tick();
      lat++;
      if (!busy && !done) gaps++;
    end while (!done && lat < 300);
  endtask
  task automatic encrypt(input logic [127:0] pt, output logic [127:0] ct, output int lat, output int gaps);
    accept(pt);
    wait_done(lat, gaps);
    ct = data_out;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (data_out !== 128'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_out); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    repeat (4) tick();
    total++; if ({data_out, done, busy} !== 130'h0) begin bad++; $display("FAIL post_reset_idle got=%h exp=0", {data_out, done, busy}); end
  endtask
  task automatic test_gost;
    logic [127:0] ct;
    int lat, gaps;
    set_gost_keys();
    encrypt(GOST_PT, ct, lat, gaps);
    total++; if (ct !== GOST_CT) begin bad++; $display("FAIL gost_ct got=%h exp=%h", ct, GOST_CT); end
    total++; if (ct !== ref_enc(GOST_PT)) begin bad++; $display("FAIL gost_model got=%h exp=%h", ct, ref_enc(GOST_PT)); end
    total++; if (lat !== 154) begin bad++; $display("FAIL gost_latency got=%0d exp=154", lat); end
    total++; if (gaps !== 0) begin bad++; $display("FAIL gost_busy_gap got=%0d exp=0", gaps); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL gost_busy_at_done got=%b exp=0", busy); end
    tick();
    total++; if (done !== 1'b0 || data_out !== GOST_CT) begin bad++; $display("FAIL gost_pulse got=%b/%h exp=0/%h", done, data_out, GOST_CT); end
  endtask
  task automatic test_gating;
    int nd, at, viol;
    logic [127:0] ct;
    viol = 0;
    block_in = GOST_PT;
    start = 1'b1;
    keys_valid = 1'b0;
    repeat (10) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0) viol++;
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL gating_no_keys got=%0d exp=0", viol); end
    accept(GOST_PT);
    nd = 0; at = 0; ct = '0;
    for (int c = 1; c <= 200; c++) begin
      if (c == 20) begin
        block_in = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        keys_valid = 1'b1;
      end else begin
        start = 1'b0;
        keys_valid = 1'b0;
      end
      tick();
      if (done) begin nd++; at = c; ct = data_out; end
    end
    total++; if (nd !== 1) begin bad++; $display("FAIL gating_done_count got=%0d exp=1", nd); end
    total++; if (at !== 154) begin bad++; $display("FAIL gating_latency got=%0d exp=154", at); end
    total++; if (ct !== GOST_CT) begin bad++; $display("FAIL gating_ct got=%h exp=%h", ct, GOST_CT); end
  endtask
  task automatic test_back_to_back;
    logic [127:0] ct1, exp2;
    int lat, gaps, holds;
    encrypt(GOST_PT, ct1, lat, gaps);
    exp2 = ref_enc(128'h0);
    accept(128'h0);
    lat = 0; holds = 0;
    do begin
      tick();
      lat++;
      if (!done && data_out !== ct1) holds++;
    end while (!done && lat < 300);
    total++; if (lat !== 154) begin bad++; $display("FAIL b2b_latency got=%0d exp=154", lat); end
    total++; if (holds !== 0) begin bad++; $display("FAIL b2b_hold got=%0d exp=0", holds); end
    total++; if (data_out !== exp2) begin bad++; $display("FAIL b2b_ct got=%h exp=%h", data_out, exp2); end
  endtask
  task automatic test_mid_reset;
    logic [127:0] ct;
    int nd, lat, gaps;
    accept(GOST_PT ^ 128'h1);
    repeat (70) tick();
    rst_n = 1'b0;
    tick();
    total++; if ({data_out, done, busy} !== 130'h0) begin bad++; $display("FAIL midreset_outputs got=%h exp=0", {data_out, done, busy}); end
    rst_n = 1'b1;
    nd = 0;
    repeat (200) begin tick(); if (done) nd++; end
    total++; if (nd !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d exp=0", nd); end
    encrypt(GOST_PT, ct, lat, gaps);
    total++; if (ct !== GOST_CT || lat !== 154) begin bad++; $display("FAIL midreset_fresh got=%h/%0d exp=%h/154", ct, lat, GOST_CT); end
  endtask
  task automatic test_l_probe;
    int lat, gaps;
    accept({8'hAC, 8'hBA, 8'h95, {13{8'hA5}}} ^ keys[1]);
    tick();
    total++; if (dut.r_st !== 128'h64a59400000000000000000000000000) begin bad++; $display("FAIL probe_s got=%h exp=64a594..", dut.r_st); end
    repeat (16) tick();
    total++; if (dut.r_st !== 128'hd456584dd0e3e84cc3166e4b7fa2890d) begin bad++; $display("FAIL probe_l got=%h exp=d456584dd0e3e84cc3166e4b7fa2890d", dut.r_st); end
    wait_done(lat, gaps);
    accept({{14{8'hA5}}, 8'h2D, 8'hA5} ^ keys[1]);
    tick();
    tick();
    total++; if (dut.r_st !== 128'h94000000000000000000000000000001) begin bad++; $display("FAIL probe_r got=%h exp=94..01", dut.r_st); end
    tick();
    total++; if (dut.r_st !== ref_l(128'h94000000000000000000000000000001, 1)) begin bad++; $display("FAIL probe_r2 got=%h exp=%h", dut.r_st, ref_l(128'h94000000000000000000000000000001, 1)); end
    wait_done(lat, gaps);
  endtask
  task automatic test_random;
    logic [127:0] pt, ct, exp;
    int lat, gaps;
    for (int n = 0; n < 5; n++) begin
      for (int k = 1; k <= 10; k++) keys[k] = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      exp = ref_enc(pt);
      encrypt(pt, ct, lat, gaps);
      total++; if (ct !== exp || lat !== 154 || gaps !== 0) begin bad++; $display("FAIL random_%0d got=%h/%0d/%0d exp=%h/154/0", n, ct, lat, gaps, exp); end
    end
  endtask
  initial begin
    set_gost_keys();
    test_reset();
    test_gost();
    test_gating();
    test_back_to_back();
    test_mid_reset();
    test_l_probe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
